// File: rtl/risc_v_lsu.sv
// RV32 load/store unit: byte-addressed core requests onto a word-addressed memory with a
// combinational read port; sub-word stores are done as read-modify-write.
module risc_v_lsu #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned MEM_SIZE   = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_we,
  input  logic [2:0]            i_req_funct3,
  input  logic [31:0]           i_req_addr,
  input  logic [DATA_WIDTH-1:0] i_req_wdata,
  output logic                  o_resp_valid,
  output logic [DATA_WIDTH-1:0] o_resp_rdata,
  output logic                  o_resp_err,
  output logic                  o_mem_write,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

  localparam logic [31:0] ByteLimit = 32'(4 * MEM_SIZE);

  typedef enum logic [1:0] {StIdle, StAccess, StWrite, StResp} state_e;

  state_e                r_state, w_state_next;
  logic                  r_we, w_we_next;
  logic [2:0]            r_funct3, w_funct3_next;
  logic [1:0]            r_off, w_off_next;
  logic [DATA_WIDTH-1:0] r_wdata, w_wdata_next;
  logic                  r_resp_valid, w_resp_valid_next;
  logic [DATA_WIDTH-1:0] r_resp_rdata, w_resp_rdata_next;
  logic                  r_resp_err, w_resp_err_next;
  logic                  r_mem_write, w_mem_write_next;
  logic [ADDR_WIDTH-1:0] r_mem_addr, w_mem_addr_next;
  logic [DATA_WIDTH-1:0] r_mem_wdata, w_mem_wdata_next;

  logic                  w_f3_ok, w_misaligned, w_req_err;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic [DATA_WIDTH-1:0] w_load, w_merged;

  // Request decode only feeds next-state logic, never the registered outputs directly.
  always_comb begin
    w_f3_ok = 1'b0;
    case (i_req_funct3)
      3'b000, 3'b001, 3'b010: w_f3_ok = 1'b1;
      3'b100, 3'b101:         w_f3_ok = ~i_req_we;
      default:                w_f3_ok = 1'b0;
    endcase
    w_misaligned = ((i_req_funct3[1:0] == 2'b01) && i_req_addr[0]) ||
                   ((i_req_funct3[1:0] == 2'b10) && (i_req_addr[1:0] != 2'b00));
    w_req_err = ~w_f3_ok || w_misaligned || (i_req_addr >= ByteLimit);
  end

  always_comb begin
    w_byte = i_mem_rdata[{r_off, 3'b000} +: 8];
    w_half = i_mem_rdata[{r_off[1], 4'b0000} +: 16];
    case (r_funct3)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_load = {24'b0, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b101:  w_load = {16'b0, w_half};
      default: w_load = i_mem_rdata;
    endcase
    w_merged = i_mem_rdata;
    if (r_funct3[1:0] == 2'b00) begin
      w_merged[{r_off, 3'b000} +: 8] = r_wdata[7:0];
    end else begin
      w_merged[{r_off[1], 4'b0000} +: 16] = r_wdata[15:0];
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_we_next         = r_we;
    w_funct3_next     = r_funct3;
    w_off_next        = r_off;
    w_wdata_next      = r_wdata;
    w_resp_valid_next = 1'b0;
    w_resp_rdata_next = r_resp_rdata;
    w_resp_err_next   = 1'b0;
    w_mem_write_next  = 1'b0;
    w_mem_addr_next   = r_mem_addr;
    w_mem_wdata_next  = r_mem_wdata;
    unique case (r_state)
      StIdle: begin
        if (i_req_valid) begin
          w_we_next     = i_req_we;
          w_funct3_next = i_req_funct3;
          w_off_next    = i_req_addr[1:0];
          w_wdata_next  = i_req_wdata;
          if (w_req_err) begin
            w_state_next      = StResp;
            w_resp_valid_next = 1'b1;
            w_resp_err_next   = 1'b1;
            w_resp_rdata_next = '0;
          end else begin
            w_state_next    = StAccess;
            w_mem_addr_next = i_req_addr[ADDR_WIDTH+1:2];
            // SW writes during ACCESS, so the strobe is armed at the accepting edge.
            if (i_req_we && (i_req_funct3 == 3'b010)) begin
              w_mem_write_next = 1'b1;
              w_mem_wdata_next = i_req_wdata;
            end
          end
        end
      end
      StAccess: begin
        if (!r_we) begin
          w_state_next      = StResp;
          w_resp_valid_next = 1'b1;
          w_resp_rdata_next = w_load;
        end else if (r_funct3 == 3'b010) begin
          w_state_next      = StResp;
          w_resp_valid_next = 1'b1;
          w_resp_rdata_next = '0;
        end else begin
          w_state_next     = StWrite;
          w_mem_write_next = 1'b1;
          w_mem_wdata_next = w_merged;
        end
      end
      StWrite: begin
        w_state_next      = StResp;
        w_resp_valid_next = 1'b1;
        w_resp_rdata_next = '0;
      end
      StResp: begin
        w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state      <= StIdle;
      r_we         <= 1'b0;
      r_funct3     <= '0;
      r_off        <= '0;
      r_wdata      <= '0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
    end else begin
      r_state      <= w_state_next;
      r_we         <= w_we_next;
      r_funct3     <= w_funct3_next;
      r_off        <= w_off_next;
      r_wdata      <= w_wdata_next;
      r_resp_valid <= w_resp_valid_next;
      r_resp_rdata <= w_resp_rdata_next;
      r_resp_err   <= w_resp_err_next;
      r_mem_write  <= w_mem_write_next;
      r_mem_addr   <= w_mem_addr_next;
      r_mem_wdata  <= w_mem_wdata_next;
    end
  end

  // Gated by reset so no request is offered while reset is held.
  assign o_req_ready  = (r_state == StIdle) && i_rst_n;
  assign o_resp_valid = r_resp_valid;
  assign o_resp_rdata = r_resp_rdata;
  assign o_resp_err   = r_resp_err;
  assign o_mem_write  = r_mem_write;
  assign o_mem_addr   = r_mem_addr;
  assign o_mem_wdata  = r_mem_wdata;

endmodule

// File: tb/tb_risc_v_lsu.sv
// Bench for risc_v_lsu: directed and random requests against a word memory, with expectations
// derived from RV32 load/store semantics on a reference array.
module tb_risc_v_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err, mem_write;
  logic [31:0] resp_rdata, mem_wdata, mem_rdata;
  logic [4:0]  mem_addr;

  logic [31:0] mem     [32];
  logic [31:0] ref_mem [32];

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  risc_v_lsu #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .MEM_SIZE(32)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .i_req_we     (req_we),
    .i_req_funct3 (req_funct3),
    .i_req_addr   (req_addr),
    .i_req_wdata  (req_wdata),
    .o_resp_valid (resp_valid),
    .o_resp_rdata (resp_rdata),
    .o_resp_err   (resp_err),
    .o_mem_write  (mem_write),
    .o_mem_addr   (mem_addr),
    .o_mem_wdata  (mem_wdata),
    .i_mem_rdata  (mem_rdata)
  );

  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_write === 1'b1) mem[mem_addr] <= mem_wdata;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit model_err(input logic we, input logic [2:0] f3, input logic [31:0] a);
    bit bad;
    if (we) bad = (f3 > 3'd2);
    else    bad = !(f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
    if ((f3 == 1 || f3 == 5) && (a % 2 != 0)) bad = 1'b1;
    if (f3 == 2 && (a % 4 != 0)) bad = 1'b1;
    if (a >= 32'd128) bad = 1'b1;
    return bad;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] w, input logic [2:0] f3,
                                             input logic [31:0] a);
    logic [31:0] v;
    int sh;
    sh = 8 * int'(a % 4);
    if (f3 == 0 || f3 == 4) begin
      v = (w >> sh) & 32'hFF;
      if (f3 == 0 && v >= 32'd128) v = v - 32'd256;
    end else if (f3 == 1 || f3 == 5) begin
      v = (w >> sh) & 32'hFFFF;
      if (f3 == 1 && v >= 32'd32768) v = v - 32'd65536;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic logic [31:0] model_store(input logic [31:0] old, input logic [2:0] f3,
                                              input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] mask;
    int sh;
    sh = 8 * int'(a % 4);
    if (f3 == 0)      mask = 32'hFF << sh;
    else if (f3 == 1) mask = 32'hFFFF << sh;
    else              mask = 32'hFFFF_FFFF;
    return (old & ~mask) | ((wd << sh) & mask);
  endfunction

  task automatic run_op(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd);
    bit          e;
    logic [31:0] exp_rd, rd;
    logic        er, rdy_resp;
    logic [4:0]  waddr;
    int          exp_lat, exp_nwr, lat, nwr, guard, idx;
    e       = model_err(we, f3, a);
    idx     = int'(a[6:2]);
    exp_rd  = (e || we) ? 32'd0 : model_load(ref_mem[idx], f3, a);
    exp_lat = e ? 1 : ((!we || f3 == 3'd2) ? 2 : 3);
    exp_nwr = (e || !we) ? 0 : 1;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    guard = 0;
    while (!req_ready && guard < 20) begin @(negedge clk); guard++; end
    check({tag, " ready"}, {31'b0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_we = 1'($urandom); req_funct3 = 3'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    lat = 0; nwr = 0; rd = 'x; er = 1'bx; rdy_resp = 1'bx; waddr = '0;
    while (lat < 8) begin
      @(negedge clk);
      lat++;
      if (mem_write === 1'b1) begin nwr++; waddr = mem_addr; end
      if (resp_valid === 1'b1) begin
        rd = resp_rdata; er = resp_err; rdy_resp = req_ready;
        break;
      end
    end
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " rdata"}, rd, exp_rd);
    check({tag, " err"}, {31'b0, er}, {31'b0, e});
    check({tag, " writes"}, 32'(nwr), 32'(exp_nwr));
    check({tag, " ready_in_resp"}, {31'b0, rdy_resp}, 32'd0);
    if (exp_nwr == 1) begin
      check({tag, " waddr"}, {27'b0, waddr}, {27'b0, a[6:2]});
      ref_mem[idx] = model_store(ref_mem[idx], f3, a, wd);
      check({tag, " memword"}, mem[idx], ref_mem[idx]);
    end
    @(negedge clk);
    check({tag, " resp_pulse"}, {31'b0, resp_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within time budget");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] v;
    for (int i = 0; i < 32; i++) begin
      v = $urandom;
      mem[i] = v;
      ref_mem[i] = v;
    end
    rst_n = 1'b0; req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h8; req_wdata = 32'h1234_5678;

    // Reset held for two edges with a pending request.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rst ready", {31'b0, req_ready}, 32'd0);
      check("rst mem_write", {31'b0, mem_write}, 32'd0);
      check("rst resp_valid", {31'b0, resp_valid}, 32'd0);
    end
    check("rst rdata", resp_rdata, 32'd0);
    check("rst err", {31'b0, resp_err}, 32'd0);
    check("rst mem_addr", {27'b0, mem_addr}, 32'd0);
    check("rst mem_wdata", mem_wdata, 32'd0);
    req_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    check("post_rst ready", {31'b0, req_ready}, 32'd1);
    @(negedge clk);

    run_op("sw08", 1'b1, 3'b010, 32'h08, 32'hDEAD_BEEF);
    run_op("lw08", 1'b0, 3'b010, 32'h08, 32'h0);
    run_op("sb09", 1'b1, 3'b000, 32'h09, 32'h0000_0012);
    check("word2 merged", mem[2], 32'hDEAD_12EF);
    run_op("lw08b", 1'b0, 3'b010, 32'h08, 32'h0);
    run_op("lb0b", 1'b0, 3'b000, 32'h0B, 32'h0);
    run_op("lbu0b", 1'b0, 3'b100, 32'h0B, 32'h0);
    run_op("lh0a", 1'b0, 3'b001, 32'h0A, 32'h0);
    run_op("lhu08", 1'b0, 3'b101, 32'h08, 32'h0);
    run_op("sh0e", 1'b1, 3'b001, 32'h0E, 32'h0000_8001);
    run_op("lh0e", 1'b0, 3'b001, 32'h0E, 32'h0);

    run_op("err_lh03", 1'b0, 3'b001, 32'h03, 32'h0);
    run_op("err_sw06", 1'b1, 3'b010, 32'h06, 32'hFFFF_FFFF);
    run_op("err_lw80", 1'b0, 3'b010, 32'h80, 32'h0);
    run_op("err_f3_011", 1'b0, 3'b011, 32'h00, 32'h0);
    run_op("err_sbu", 1'b1, 3'b100, 32'h04, 32'h55);
    run_op("last_word", 1'b0, 3'b010, 32'h7C, 32'h0);

    // SH abandoned by a reset sampled at the edge that ends ACCESS.
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b001;
    req_addr = 32'h10; req_wdata = 32'h0000_A5A5;
    check("abort ready", {31'b0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("abort access mem_write", {31'b0, mem_write}, 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("abort mem_write", {31'b0, mem_write}, 32'd0);
      check("abort resp_valid", {31'b0, resp_valid}, 32'd0);
      @(negedge clk);
    end
    check("abort memword", mem[4], ref_mem[4]);
    run_op("lw10_after_abort", 1'b0, 3'b010, 32'h10, 32'h0);

    for (int i = 0; i < 60; i++) begin
      run_op($sformatf("rnd%0d", i), 1'($urandom), 3'($urandom),
             32'($urandom_range(0, 135)), $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
